// File: rtl/rfa_arbiter.sv
// Register-file write-back arbiter: LSU priority, round-robin among ALU queues.
// Define RFA_STARVE_GUARD_EN to cap consecutive LSU grants while ALUs are waiting.
module rfa_arbiter #(
    parameter int NUM_ALU        = 8,
    parameter int LSU_STREAK_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_ALU-1:0] alu_queue_entry_valid,
    input  logic               lsu_dest_wr_req,
    output logic [NUM_ALU-1:0] alu_queue_entry_serviced,
    output logic               lsu_dest_wr_grant,
    output logic [NUM_ALU:0]   wr_port_select,
    output logic               grant_valid
);

    localparam int               PTR_W    = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_ALU - 1);

    // The streak counter is 3 bits wide, so the cap must fit in it.
    if (NUM_ALU < 2 || LSU_STREAK_MAX < 1 || LSU_STREAK_MAX > 7) begin : g_bad_cfg
        $error("rfa_arbiter: unsupported NUM_ALU / LSU_STREAK_MAX");
    end

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_ALU-1:0] w_hi_mask;
    logic [NUM_ALU-1:0] w_req_hi;
    logic               w_hi_found;
    logic [PTR_W-1:0]   w_hi_idx;
    logic               w_lo_found;
    logic [PTR_W-1:0]   w_lo_idx;
    logic               w_alu_found;
    logic [PTR_W-1:0]   w_alu_idx;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_force_alu;
    logic               w_lsu_win;
    logic               w_alu_win;

    // Round-robin: first request at or above the pointer, else wrap to the lowest request.
    always_comb begin
        w_hi_mask  = {NUM_ALU{1'b1}} << r_rr_ptr;
        w_req_hi   = alu_queue_entry_valid & w_hi_mask;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = NUM_ALU - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_hi_found = 1'b1;
                w_hi_idx   = PTR_W'(i);
            end
            if (alu_queue_entry_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = PTR_W'(i);
            end
        end
    end

    assign w_alu_found = w_lo_found;
    assign w_alu_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_ptr_next  = (w_alu_idx == LAST_IDX) ? '0 : w_alu_idx + PTR_W'(1);

    // Gating with rst keeps every output low for the whole reset window.
    assign w_lsu_win = rst & lsu_dest_wr_req & ~w_force_alu;
    assign w_alu_win = rst & w_alu_found & ~w_lsu_win;

    assign alu_queue_entry_serviced = w_alu_win ? (NUM_ALU'(1) << w_alu_idx) : '0;
    assign lsu_dest_wr_grant        = w_lsu_win;
    assign wr_port_select           = {w_lsu_win, alu_queue_entry_serviced};
    assign grant_valid              = w_lsu_win | w_alu_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_alu_win) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

`ifdef RFA_STARVE_GUARD_EN
    localparam logic [2:0] STREAK_MAX = 3'(LSU_STREAK_MAX);

    logic [2:0] r_lsu_streak;
    logic       w_alu_pending;

    assign w_alu_pending = |alu_queue_entry_valid;
    assign w_force_alu   = w_alu_pending && (r_lsu_streak == STREAK_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lsu_streak <= '0;
        end else if (w_lsu_win) begin
            if (!w_alu_pending) begin
                r_lsu_streak <= '0;
            end else if (r_lsu_streak != STREAK_MAX) begin
                r_lsu_streak <= r_lsu_streak + 3'd1;
            end
        end else if (w_alu_win) begin
            r_lsu_streak <= '0;
        end
    end
`else
    assign w_force_alu = 1'b0;
`endif

endmodule

// File: tb/tb_rfa_arbiter.sv
// Self-checking bench for rfa_arbiter: directed scenarios plus random traffic
// compared against a rule-level reference model.
module tb_rfa_arbiter;

    localparam int NA   = 8;
    localparam int SMAX = 4;

`ifdef RFA_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NA-1:0] alu_v = '0;
    logic          lsu_req = 1'b0;
    logic [NA-1:0] serviced;
    logic          lsu_grant;
    logic [NA:0]   sel;
    logic          gvalid;

    int n_checks = 0;
    int n_errors = 0;

    int            m_ptr;
    int            m_streak;
    logic [NA-1:0] exp_alu;
    logic          exp_lsu;

    rfa_arbiter #(.NUM_ALU(NA), .LSU_STREAK_MAX(SMAX)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .alu_queue_entry_valid    (alu_v),
        .lsu_dest_wr_req          (lsu_req),
        .alu_queue_entry_serviced (serviced),
        .lsu_dest_wr_grant        (lsu_grant),
        .wr_port_select           (sel),
        .grant_valid              (gvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_ptr    = 0;
        m_streak = 0;
    endtask

    task automatic m_eval();
        bit any_alu;
        bit force_alu;
        any_alu   = (alu_v != '0);
        force_alu = GUARD && (m_streak == SMAX) && any_alu;
        exp_alu   = '0;
        exp_lsu   = 1'b0;
        if (lsu_req && !force_alu) begin
            exp_lsu = 1'b1;
        end else begin
            for (int i = 0; i < NA; i++) begin
                int k;
                k = (m_ptr + i) % NA;
                if (alu_v[k]) begin
                    exp_alu[k] = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic m_commit();
        if (exp_lsu) begin
            if (alu_v != '0) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
            else             m_streak = 0;
        end else if (exp_alu != '0) begin
            for (int i = 0; i < NA; i++)
                if (exp_alu[i]) m_ptr = (i + 1) % NA;
            m_streak = 0;
        end
    endtask

    task automatic drive(input logic [NA-1:0] v, input logic l);
        @(negedge clk);
        alu_v   = v;
        lsu_req = l;
        #1;
        m_eval();
    endtask

    task automatic do_reset();
        @(negedge clk);
        alu_v   = '0;
        lsu_req = 1'b0;
        rst     = 1'b0;
        #2;
        rst = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b0;
        alu_v   = '1;
        lsu_req = 1'b1;
        #1;
        n_checks++;
        if (serviced !== '0) begin
            n_errors++; $display("FAIL reset_serviced: got %h expected 00", serviced);
        end
        n_checks++;
        if (lsu_grant !== 1'b0) begin
            n_errors++; $display("FAIL reset_lsu_grant: got %b expected 0", lsu_grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sel !== '0) begin
            n_errors++; $display("FAIL reset_sel_after_edge: got %h expected 000", sel);
        end
        n_checks++;
        if (gvalid !== 1'b0) begin
            n_errors++; $display("FAIL reset_grant_valid: got %b expected 0", gvalid);
        end
        @(negedge clk);
        rst     = 1'b1;
        lsu_req = 1'b0;
        #1;
        m_reset();
        m_eval();
        n_checks++;
        if (serviced !== 8'h01) begin
            n_errors++; $display("FAIL reset_first_grant: got %h expected 01", serviced);
        end
        n_checks++;
        if (serviced !== exp_alu) begin
            n_errors++; $display("FAIL reset_first_model: got %h expected %h", serviced, exp_alu);
        end
        m_commit();
    endtask

    task automatic test_rotation();
        logic [NA-1:0] exp_rot;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive('1, 1'b0);
            exp_rot = 8'h01 << (c % NA);
            n_checks++;
            if (serviced !== exp_rot) begin
                n_errors++; $display("FAIL rotation_c%0d: got %h expected %h", c, serviced, exp_rot);
            end
            n_checks++;
            if (sel[NA] !== 1'b0) begin
                n_errors++; $display("FAIL rotation_lsu_sel_c%0d: got %b expected 0", c, sel[NA]);
            end
            n_checks++;
            if (serviced !== exp_alu) begin
                n_errors++; $display("FAIL rotation_model_c%0d: got %h expected %h", c, serviced, exp_alu);
            end
            m_commit();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(8'h02, 1'b0);
        n_checks++;
        if (serviced !== 8'h02) begin
            n_errors++; $display("FAIL wrap_setup: got %h expected 02", serviced);
        end
        m_commit();
        drive(8'h12, 1'b0);
        n_checks++;
        if (serviced !== 8'h10) begin
            n_errors++; $display("FAIL wrap_alu4_first: got %h expected 10", serviced);
        end
        m_commit();
        drive(8'h02, 1'b0);
        n_checks++;
        if (serviced !== 8'h02) begin
            n_errors++; $display("FAIL wrap_alu1_second: got %h expected 02", serviced);
        end
        m_commit();
        drive(8'h00, 1'b0);
        n_checks++;
        if (sel !== '0 || gvalid !== 1'b0) begin
            n_errors++; $display("FAIL wrap_idle: got sel %h gv %b expected 000 0", sel, gvalid);
        end
        m_commit();
    endtask

    task automatic test_lsu_streak();
        logic        alu_turn;
        logic [NA:0] exp_sel;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive(8'h08, 1'b1);
`ifdef RFA_STARVE_GUARD_EN
            alu_turn = ((c % (SMAX + 1)) == SMAX);
`else
            alu_turn = 1'b0;
`endif
            exp_sel = alu_turn ? {1'b0, 8'h08} : {1'b1, 8'h00};
            n_checks++;
            if (sel !== exp_sel) begin
                n_errors++; $display("FAIL streak_sel_c%0d: got %h expected %h", c, sel, exp_sel);
            end
            n_checks++;
            if (lsu_grant !== exp_lsu || serviced !== exp_alu) begin
                n_errors++; $display("FAIL streak_model_c%0d: got lsu %b alu %h expected lsu %b alu %h",
                                     c, lsu_grant, serviced, exp_lsu, exp_alu);
            end
            m_commit();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(8'h40, 1'b0);
        m_commit();
        drive(8'h20, 1'b0);
        n_checks++;
        if (serviced !== 8'h20) begin
            n_errors++; $display("FAIL areset_pre: got %h expected 20", serviced);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (serviced !== '0 || gvalid !== 1'b0) begin
            n_errors++; $display("FAIL areset_drop: got %h gv %b expected 00 0", serviced, gvalid);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_eval();
        n_checks++;
        if (serviced !== 8'h20 || serviced !== exp_alu) begin
            n_errors++; $display("FAIL areset_regrant: got %h expected 20 (model %h)", serviced, exp_alu);
        end
        m_commit();
        drive(8'h00, 1'b0);
        m_commit();
    endtask

    task automatic test_random();
        logic [NA-1:0] v;
        logic          l;
        logic [NA-1:0] prev_alu;
        logic          prev_lsu;
        int            wait_cnt [NA];
        int            worst;
        // Between two ALU grants at most SMAX LSU grants slip in, and a waiting ALU
        // may see every other ALU served first.
        int            bound;
        bound    = (SMAX + 1) * NA;
        v        = '0;
        l        = 1'b0;
        prev_alu = '0;
        prev_lsu = 1'b0;
        for (int i = 0; i < NA; i++) wait_cnt[i] = 0;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NA; i++) begin
                if (prev_alu[i])                                v[i] = 1'b0;
                else if (!v[i] && $urandom_range(0, 3) == 0)    v[i] = 1'b1;
            end
            if (prev_lsu)                                       l = 1'b0;
            else if (!l && $urandom_range(0, 3) != 0)           l = 1'b1;
            drive(v, l);
            n_checks++;
            if (serviced !== exp_alu || lsu_grant !== exp_lsu) begin
                n_errors++; $display("FAIL random_grant_cyc%0d: got lsu %b alu %h expected lsu %b alu %h (req %b %h)",
                                     cyc, lsu_grant, serviced, exp_lsu, exp_alu, l, v);
            end
            n_checks++;
            if (sel !== {exp_lsu, exp_alu} || gvalid !== (exp_lsu | (|exp_alu))) begin
                n_errors++; $display("FAIL random_sel_cyc%0d: got sel %h gv %b expected %h %b",
                                     cyc, sel, gvalid, {exp_lsu, exp_alu}, exp_lsu | (|exp_alu));
            end
            n_checks++;
            if ($countones(sel) > 1) begin
                n_errors++; $display("FAIL random_onehot_cyc%0d: got sel %h expected one-hot or zero", cyc, sel);
            end
            n_checks++;
            if ((serviced & ~v) != '0 || (lsu_grant && !l)) begin
                n_errors++; $display("FAIL random_unrequested_cyc%0d: got alu %h lsu %b for req %h %b",
                                     cyc, serviced, lsu_grant, v, l);
            end
            worst = 0;
            for (int i = 0; i < NA; i++) begin
                if (v[i] && !exp_alu[i]) wait_cnt[i]++;
                else                     wait_cnt[i] = 0;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
`ifdef RFA_STARVE_GUARD_EN
            n_checks++;
            if (worst > bound) begin
                n_errors++; $display("FAIL random_starve_cyc%0d: got wait %0d expected <= %0d", cyc, worst, bound);
            end
`endif
            prev_alu = exp_alu;
            prev_lsu = exp_lsu;
            m_commit();
        end
        drive('0, 1'b0);
    endtask

    initial begin
        m_reset();
        exp_alu = '0;
        exp_lsu = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_lsu_streak();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
